signmag_accumulator: RTL and testbench

Sequential sign-magnitude accumulator, the parametrised successor to the combinational sign-magnitude adder. It holds a running N-bit sign-magnitude total and applies one operation per accepted request: add, subtract, load or clear. A valid/ready handshake sits on the input side. Results have a registered done pulse, overflow detection, selectable saturate/wrap behaviour, and a sticky overflow flag. It sits between an operand source (switches/UART decoder) and the display/readback path.

---
 rtl/signmag_accumulator.sv | 129 ++++++++++++
 tb/tb_signmag_accumulator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/signmag_accumulator.sv
// Sign-magnitude running total: ADD/SUB/LOAD/CLEAR, one op per 3 cycles (accept, execute, done pulse).
// Backpressure: in_ready is high only in IDLE; the source holds in_valid until it is accepted.
module signmag_accumulator #(
   parameter int N   = 8,
   parameter bit SAT = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [N-1:0] din,
   output logic [N-1:0] acc_out,
   output logic         out_valid,
   output logic         ovf,
   output logic         sticky_ovf
);

   localparam int M = N - 1;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t         r_state;
   logic [1:0]     r_op;
   logic [N-1:0]   r_din;
   logic [N-1:0]   r_acc;
   logic           r_out_valid;
   logic           r_ovf;
   logic           r_sticky;

   logic           w_a_sign;
   logic [M-1:0]   w_a_mag;
   logic           w_b_sign;
   logic [M-1:0]   w_b_mag;
   logic [N-1:0]   w_sum;
   logic           w_add_ovf;
   logic           w_res_sign;
   logic [M-1:0]   w_res_mag;
   logic [N-1:0]   w_next;
   logic           w_ovf;

   always_comb begin
      w_a_sign   = r_acc[N-1];
      w_a_mag    = r_acc[M-1:0];
      // SUB is ADD with the operand's sign flipped
      w_b_sign   = r_din[N-1] ^ (r_op == OP_SUB);
      w_b_mag    = r_din[M-1:0];
      w_sum      = {1'b0, w_a_mag} + {1'b0, w_b_mag};
      w_add_ovf  = 1'b0;
      w_res_sign = 1'b0;
      w_res_mag  = '0;
      if (w_a_sign == w_b_sign) begin
         w_res_sign = w_a_sign;
         w_add_ovf  = w_sum[N-1];
         w_res_mag  = (w_add_ovf && SAT) ? {M{1'b1}} : w_sum[M-1:0];
      end else if (w_a_mag >= w_b_mag) begin
         w_res_sign = w_a_sign;
         w_res_mag  = w_a_mag - w_b_mag;
      end else begin
         w_res_sign = w_b_sign;
         w_res_mag  = w_b_mag - w_a_mag;
      end

      w_next = '0;
      w_ovf  = 1'b0;
      case (r_op)
         OP_ADD, OP_SUB: begin
            // a zero magnitude never carries a negative sign
            w_next = {w_res_sign & (|w_res_mag), w_res_mag};
            w_ovf  = w_add_ovf;
         end
         OP_LOAD:  w_next = {r_din[N-1] & (|r_din[M-1:0]), r_din[M-1:0]};
         default:  w_next = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_op        <= OP_ADD;
         r_din       <= '0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_sticky    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_out_valid <= 1'b0;
               if (in_valid) begin
                  r_op    <= op;
                  r_din   <= din;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_acc       <= w_next;
               r_ovf       <= w_ovf;
               r_out_valid <= 1'b1;
               if (r_op == OP_CLEAR)
                  r_sticky <= 1'b0;
               else if (w_ovf)
                  r_sticky <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = (r_state == S_IDLE);
   assign acc_out    = r_acc;
   assign out_valid  = r_out_valid;
   assign ovf        = r_ovf;
   assign sticky_ovf = r_sticky;

endmodule

// File: tb/tb_signmag_accumulator.sv
// Directed bench: saturating and wrapping instances share one stimulus stream.
module tb_signmag_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [1:0] op;
   logic [7:0] din;

   logic       rdy1, ov1, ovf1, st1;
   logic [7:0] acc1;
   logic       rdy0, ov0, ovf0, st0;
   logic [7:0] acc0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   signmag_accumulator #(.N(8), .SAT(1'b1)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .op(op), .din(din),
      .acc_out(acc1), .out_valid(ov1), .ovf(ovf1), .sticky_ovf(st1)
   );

   signmag_accumulator #(.N(8), .SAT(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .op(op), .din(din),
      .acc_out(acc0), .out_valid(ov0), .ovf(ovf0), .sticky_ovf(st0)
   );

   typedef struct {
      logic [1:0] op;
      logic [7:0] din;
      logic [7:0] exp_sat;
      logic [7:0] exp_wrap;
      logic       exp_ovf;
      logic       exp_sticky;
   } vec_t;

   localparam int NV = 19;
   vec_t vt[NV];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Returns at the falling edge where out_valid is high (ok=1), or after a bounded wait.
   task automatic do_op(input logic [1:0] o, input logic [7:0] d, output logic ok);
      int n;
      ok = 1'b0;
      n  = 0;
      @(negedge clk);
      while (!rdy1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b1;
      op       = o;
      din      = d;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!ov1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      ok = ov1;
   endtask

   initial begin
      logic ok;
      logic seen_ov;

      //          op     din    sat    wrap   ovf   sticky
      vt[0]  = '{2'b11, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[1]  = '{2'b10, 8'h64, 8'h64, 8'h64, 1'b0, 1'b0};
      vt[2]  = '{2'b00, 8'h32, 8'h7F, 8'h16, 1'b1, 1'b1};
      vt[3]  = '{2'b10, 8'h01, 8'h01, 8'h01, 1'b0, 1'b1};
      vt[4]  = '{2'b11, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[5]  = '{2'b10, 8'h05, 8'h05, 8'h05, 1'b0, 1'b0};
      vt[6]  = '{2'b01, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[7]  = '{2'b10, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[8]  = '{2'b10, 8'h94, 8'h94, 8'h94, 1'b0, 1'b0};
      vt[9]  = '{2'b00, 8'h1E, 8'h0A, 8'h0A, 1'b0, 1'b0};
      vt[10] = '{2'b01, 8'h14, 8'h8A, 8'h8A, 1'b0, 1'b0};
      vt[11] = '{2'b00, 8'h8A, 8'h94, 8'h94, 1'b0, 1'b0};
      vt[12] = '{2'b01, 8'h94, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[13] = '{2'b10, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
      vt[14] = '{2'b01, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1};
      vt[15] = '{2'b00, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b1};
      vt[16] = '{2'b11, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[17] = '{2'b10, 8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b0};
      vt[18] = '{2'b00, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b1};

      rst      = 1'b1;
      in_valid = 1'b0;
      op       = 2'b00;
      din      = 8'h00;
      #1;
      chk ("rst_acc_sat",  acc1, 8'h00);
      chk ("rst_acc_wrap", acc0, 8'h00);
      chk1("rst_out_valid", ov1 | ov0, 1'b0);
      chk1("rst_ovf",       ovf1 | ovf0, 1'b0);
      chk1("rst_sticky",    st1 | st0, 1'b0);
      chk1("rst_in_ready",  rdy1, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         do_op(vt[i].op, vt[i].din, ok);
         chk1($sformatf("v%0d_pulse", i),       ok & ov0, 1'b1);
         chk ($sformatf("v%0d_acc_sat", i),     acc1, vt[i].exp_sat);
         chk ($sformatf("v%0d_acc_wrap", i),    acc0, vt[i].exp_wrap);
         chk1($sformatf("v%0d_ovf_sat", i),     ovf1, vt[i].exp_ovf);
         chk1($sformatf("v%0d_ovf_wrap", i),    ovf0, vt[i].exp_ovf);
         chk1($sformatf("v%0d_sticky_sat", i),  st1, vt[i].exp_sticky);
         chk1($sformatf("v%0d_sticky_wrap", i), st0, vt[i].exp_sticky);
         chk1($sformatf("v%0d_busy", i),        rdy1, 1'b0);
      end

      // Reset in the middle of EXEC: op is lost, everything clears at once.
      @(negedge clk);
      chk1("mid_rst_idle_before", rdy1, 1'b1);
      in_valid = 1'b1;
      op       = 2'b10;
      din      = 8'h33;
      @(posedge clk);
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      chk ("mid_rst_acc_sat",  acc1, 8'h00);
      chk ("mid_rst_acc_wrap", acc0, 8'h00);
      chk1("mid_rst_sticky",   st1 | st0, 1'b0);
      chk1("mid_rst_ovf",      ovf1 | ovf0, 1'b0);
      chk1("mid_rst_out_valid", ov1 | ov0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk1("mid_rst_ready_after", rdy1 & rdy0, 1'b1);
      seen_ov = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         seen_ov = seen_ov | ov1 | ov0;
      end
      chk1("mid_rst_no_pulse", seen_ov, 1'b0);
      chk ("mid_rst_acc_hold", acc1, 8'h00);

      // Back-to-back: in_valid held high with ADD +1, accepts every third edge.
      in_valid = 1'b1;
      op       = 2'b00;
      din      = 8'h01;
      for (int c = 0; c < 12; c++) begin
         chk1($sformatf("tp_c%0d_ready", c),     rdy1, (c % 3) == 0);
         chk1($sformatf("tp_c%0d_out_valid", c), ov1,  (c % 3) == 2);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk ("tp_final_acc_sat",  acc1, 8'h04);
      chk ("tp_final_acc_wrap", acc0, 8'h04);
      chk1("tp_final_ovf",      ovf1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
